// File: rtl/countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_timer : loadable down-counter with rate divider, pause,         |
// |                   auto-reload and expiry pulse.            Rev 1.0        |
// +--------------------------------------------------------------------------+
module countdown_timer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIV_MAX = 49999999
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tick_o,
    output logic             done_o,
    output logic             zero_o,
    output logic             running_o
);

    // A zero-width divider is not legal, so DIV_MAX = 0 still gets one bit.
    localparam int unsigned DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    localparam logic [DW-1:0]    C_DIV_INIT = DW'(DIV_MAX);
    localparam logic [DW-1:0]    C_DIV_ONE  = DW'(1);
    localparam logic [DW-1:0]    C_DIV_ZERO = '0;
    localparam logic [WIDTH-1:0] C_Q_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_Q_ZERO   = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] reload_q;
    logic [DW-1:0]    div_q;
    logic             tick_q;
    logic             done_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            q_q      <= C_Q_ZERO;
            reload_q <= C_Q_ZERO;
            div_q    <= C_DIV_INIT;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (load_i) begin
                reload_q <= load_value_i;
                q_q      <= load_value_i;
                div_q    <= C_DIV_INIT;
                state_q  <= (load_value_i != C_Q_ZERO) ? S_RUN : S_IDLE;
            end else if (state_q == S_RUN && enable_i) begin
                if (div_q != C_DIV_ZERO) begin
                    div_q <= div_q - C_DIV_ONE;
                end else begin
                    div_q  <= C_DIV_INIT;
                    tick_q <= 1'b1;
                    if (q_q > C_Q_ONE) begin
                        q_q <= q_q - C_Q_ONE;
                    end else begin
                        // q is 1 here: RUN is never entered or kept with q = 0.
                        done_q <= 1'b1;
                        if (auto_reload_i) begin
                            q_q <= reload_q;
                        end else begin
                            q_q     <= C_Q_ZERO;
                            state_q <= S_EXPIRED;
                        end
                    end
                end
            end
        end
    end

    assign q_o       = q_q;
    assign tick_o    = tick_q;
    assign done_o    = done_q;
    assign zero_o    = (q_q == C_Q_ZERO);
    assign running_o = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// Scoreboard bench for countdown_timer (DIV_MAX = 3): stimulus queues expected
// tick events, a monitor pops one per observed tick/done.
module tb_countdown_timer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DIV_MAX = 3;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             done;
        int unsigned      edge_no;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             load_i;
    logic [WIDTH-1:0] load_value_i;
    logic             enable_i;
    logic             auto_reload_i;
    logic [WIDTH-1:0] q_o;
    logic             tick_o;
    logic             done_o;
    logic             zero_o;
    logic             running_o;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned edge_n = 0;
    int unsigned k;
    logic        zero_seen;

    countdown_timer #(.WIDTH(WIDTH), .DIV_MAX(DIV_MAX)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .enable_i     (enable_i),
        .auto_reload_i(auto_reload_i),
        .q_o          (q_o),
        .tick_o       (tick_o),
        .done_o       (done_o),
        .zero_o       (zero_o),
        .running_o    (running_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_n <= edge_n + 1;

    // Monitor: every tick or done pulse must match the head of the scoreboard.
    always @(posedge clk_i) begin
        #1;
        if (tick_o || done_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got tick=%b done=%b q=%0d at edge %0d, required no event",
                         tick_o, done_o, q_o, edge_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (tick_o !== 1'b1 || q_o !== e.q || done_o !== e.done || edge_n != e.edge_no) begin
                    n_fail++;
                    $display("FAIL tick_event: got tick=%b q=%0d done=%b edge=%0d, required tick=1 q=%0d done=%b edge=%0d",
                             tick_o, q_o, done_o, edge_n, e.q, e.done, e.edge_no);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] q, input logic done, input int unsigned e);
        exp_t x;
        x.q       = q;
        x.done    = done;
        x.edge_no = e;
        sb.push_back(x);
    endtask

    task automatic load_val(input logic [WIDTH-1:0] v);
        load_i       = 1'b1;
        load_value_i = v;
        step(1);
        load_i       = 1'b0;
        k            = edge_n;
    endtask

    task automatic check_drained(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 2 cycles while a load is requested.
        reset_ni      = 1'b0;
        load_i        = 1'b1;
        load_value_i  = 8'd7;
        enable_i      = 1'b1;
        auto_reload_i = 1'b0;
        step(2);
        check("reset_q", q_o, 0);
        check("reset_tick", tick_o, 0);
        check("reset_done", done_o, 0);
        check("reset_zero", zero_o, 1);
        check("reset_running", running_o, 0);
        reset_ni = 1'b1;
        load_i   = 1'b0;
        step(2);
        check("idle_q_hold", q_o, 0);

        // Basic count 5..0, one step every 4 edges.
        load_val(8'd5);
        check("basic_load_q", q_o, 5);
        check("basic_load_running", running_o, 1);
        check("basic_load_tick", tick_o, 0);
        push(8'd4, 1'b0, k + 4);
        push(8'd3, 1'b0, k + 8);
        push(8'd2, 1'b0, k + 12);
        push(8'd1, 1'b0, k + 16);
        push(8'd0, 1'b1, k + 20);
        step(21);
        check_drained("basic_drained");
        step(20);
        check("expired_q", q_o, 0);
        check("expired_zero", zero_o, 1);
        check("expired_running", running_o, 0);

        // Auto-reload 2,1,2,1,... then cleared so the next expiry stops.
        auto_reload_i = 1'b1;
        load_val(8'd2);
        push(8'd1, 1'b0, k + 4);
        push(8'd2, 1'b1, k + 8);
        push(8'd1, 1'b0, k + 12);
        push(8'd2, 1'b1, k + 16);
        push(8'd1, 1'b0, k + 20);
        push(8'd0, 1'b1, k + 24);
        zero_seen = zero_o;
        for (int i = 0; i < 23; i++) begin
            step(1);
            if (zero_o) zero_seen = 1'b1;
            if (edge_n == k + 17) auto_reload_i = 1'b0;
        end
        check("autoreload_zero_never", zero_seen, 0);
        step(2);
        check("autoreload_end_q", q_o, 0);
        check("autoreload_end_running", running_o, 0);
        check_drained("autoreload_drained");

        // Pause: enable low for 10 edges starting 2 edges after the load.
        load_val(8'd3);
        step(1);
        enable_i = 1'b0;
        step(10);
        check("pause_q_frozen", q_o, 3);
        check("pause_running", running_o, 1);
        enable_i = 1'b1;
        push(8'd2, 1'b0, k + 14);
        push(8'd1, 1'b0, k + 18);
        push(8'd0, 1'b1, k + 22);
        step(12);
        check_drained("pause_drained");

        // Load collides with the expiry edge (div = 0, q = 1).
        load_val(8'd1);
        step(3);
        load_val(8'd9);
        check("collide_q", q_o, 9);
        check("collide_tick", tick_o, 0);
        check("collide_done", done_o, 0);
        check("collide_running", running_o, 1);
        load_val(8'd0);
        check("load0_q", q_o, 0);
        check("load0_zero", zero_o, 1);
        check("load0_running", running_o, 0);
        check("load0_done", done_o, 0);
        step(10);
        check_drained("collide_drained");

        // Reset mid-count, landing on the edge that would have ticked.
        load_val(8'd5);
        push(8'd4, 1'b0, k + 4);
        push(8'd3, 1'b0, k + 8);
        step(11);
        check("midreset_pre_q", q_o, 3);
        reset_ni = 1'b0;
        step(1);
        check("midreset_q", q_o, 0);
        check("midreset_running", running_o, 0);
        check("midreset_tick", tick_o, 0);
        check("midreset_done", done_o, 0);
        reset_ni = 1'b1;
        step(12);
        check("postreset_q", q_o, 0);
        check("postreset_running", running_o, 0);
        check_drained("midreset_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a built-in rate divider. It counts a value down to zero at a fixed tick rate, with pause, auto-reload and expiry signalling. It is the counting-down counterpart of the up-counting T-flip-flop counter in the lab designs. Its `q` output drives the two-digit hex seven-segment display path, and its `done` pulse feeds downstream control logic.

## Interface
- `WIDTH`, default 8: count width in bits.
- `DIV_MAX`, default 49999999: rate-divider terminal value. The count period is DIV_MAX+1 clocks, which is 1 Hz at 50 MHz.
- `clk`  in  1: the only clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-low; sampled on posedge `clk`.
- `load`  in  1: load request.
- `load_value`  in  WIDTH: start and reload value, captured when `load`=1.
- `enable`  in  1: 1 = count, 0 = pause.
- `auto_reload`  in  1: 1 = restart from the stored value on expiry.
- `q`  out  WIDTH: current count, registered.
- `tick`  out  1: registered one-cycle pulse, asserted when `q` has just decremented or reloaded.
- `done`  out  1: registered one-cycle pulse, asserted when the count has just expired.
- `zero`  out  1: combinational, `q == 0`.
- `running`  out  1: combinational, state == RUN.

## Operation
- Internal registers:
  - `q`.
  - `reload_reg` (WIDTH bits).
  - Divider `div`, ceil(log2(DIV_MAX+1)) bits wide, counting down.
  - State register with states IDLE, RUN, EXPIRED.
- Reset (`reset`=0 at an edge): state=IDLE, `q`=0, `reload_reg`=0, `div`=DIV_MAX, `tick`=0, `done`=0. As a result `zero`=1 and `running`=0. Reset overrides every other input.
- Priority at each edge: reset > load > counting.
- Load (any state): `reload_reg`←`load_value`, `q`←`load_value`, `div`←DIV_MAX, `tick`=0, `done`=0.
  - Next state is RUN if `load_value`≠0, otherwise IDLE.
- IDLE: `q` and `div` hold. Exits only on load.
- RUN, `enable`=0: `q` and `div` frozen; `tick`=0, `done`=0.
- RUN, `enable`=1, `div`≠0: `div`←`div`-1.
- RUN, `enable`=1, `div`=0: `div`←DIV_MAX, `tick`←1, then:
  - If `q`>1: `q`←`q`-1.
  - If `q`=1 and `auto_reload`=0: `q`←0, `done`←1, state←EXPIRED.
  - If `q`=1 and `auto_reload`=1: `q`←`reload_reg`, `done`←1, state stays RUN. `q` never shows 0 in this case.
- EXPIRED: `q`=0 and `div` hold; `tick` and `done` stay 0 regardless of `enable`. Exits only on load.
- `auto_reload` is sampled only at the expiry edge; changing it at any other time has no effect.
- Arithmetic: unsigned.
  - `q`=0 is never decremented in RUN, because the `q`=1 rule intercepts expiry.
  - Underflow (wrap to 2^WIDTH-1) is impossible by construction.
- `tick` and `done` deassert at the edge after they were set, unless that edge sets them again. Setting them again can only happen when DIV_MAX=0.

## Timing
- Load accepted at edge k: `q`=`load_value` from edge k.
- With `enable` held at 1, the first decrement is at edge k+DIV_MAX+1. After that, one decrement every DIV_MAX+1 edges.
- `tick` and `done` are high during exactly the cycle following the edge that updated `q`. They align with the new `q` value.
- Total time from load of N (no auto-reload) to `done`: N·(DIV_MAX+1) clocks.
- Pausing for P enabled-low cycles delays every subsequent event by exactly P cycles. No divider progress is lost or gained.
- DIV_MAX=0 is legal: the count decrements every enabled clock, and `tick` stays high continuously while counting.
- Reset mid-operation takes effect at the next edge. There is no partial or late pulse of `tick` or `done` after that edge.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `load`=1 and `load_value`=7.
  - Required: `q`=0, IDLE, `tick`=`done`=0, `zero`=1, `running`=0.
  - `load` is ignored while reset is asserted.
- Basic count (DIV_MAX=3): load 5, `enable`=1, `auto_reload`=0.
  - Required: `q` reads 5,4,3,2,1,0, changing every 4 cycles.
  - `tick` fires 5 times; `done` fires once, aligned with `q`=0.
  - EXPIRED afterwards: `q`=0 and no `tick` for 20 further cycles.
- Auto-reload (DIV_MAX=3): load 2, `auto_reload`=1.
  - Required: `q` reads 2,1,2,1,…; `done` pulses at every 1→2 transition; `zero` is never asserted.
  - Clearing `auto_reload` mid-run: the next expiry lands in EXPIRED.
- Pause (DIV_MAX=3): load 3, drop `enable` for 10 cycles 2 cycles after the load, then raise it.
  - Required: `q` and `div` frozen during the pause; first decrement occurs 14 cycles after the load.
- Load collisions:
  - Assert `load` with `load_value`=9 on the edge where `div`=0 and `q`=1. Required: `q`=9, no `tick`, no `done`, state RUN.
  - Load 0 during RUN. Required: IDLE, `q`=0, `zero`=1, `done`=0.
- Reset mid-count: assert reset when `q`=3 in RUN.
  - Required: `q`=0 and IDLE after the next edge.
  - After releasing reset with `enable`=1: `q` stays 0 and no `tick` occurs until a load.
